loopback_err_counter: RTL and testbench

//  Checks the 10GbE/XAUI loopback receive stream against a locally regenerated incrementing pattern
//  and accumulates mismatches into a saturating 32-bit error count.
//  err_cnt drives user_data_in of the loop_err_cnt software register (opb_register_simulink2ppc);
//  the PPC reads it over OPB. Runs entirely in the fabric user clock domain.

---
 rtl/loopback_err_pkg.sv | 19 +
 rtl/loopback_popcount.sv | 34 +++
 rtl/loopback_err_counter.sv | 113 +++++++++++
 tb/tb_loopback_err_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/loopback_err_pkg.sv
// Shared types and constants for the loopback error counter.
// The bit-error feature is selected with the LOOPBACK_ERR_CNT_BITERR_EN macro.
package loopback_err_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lb_state_e;

  localparam int                CNT_W   = 32;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam int                MISS_W  = 4;

  // Width needed to hold a population count of a data_w-bit word.
  function automatic int pop_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/loopback_popcount.sv
// Registered population count, one pipeline stage, used by the bit-error build
// (LOOPBACK_ERR_CNT_BITERR_EN) so the error count keeps the same latency as word mode.
module loopback_popcount
  import loopback_err_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int POP_W  = pop_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  output logic [POP_W-1:0]  count_o
);

  logic [POP_W-1:0] count_d;
  logic [POP_W-1:0] count_q;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count_d = count_d + POP_W'(data_i[i]);
    end
  end

  // NOTE: reset sits in the sensitivity list, so assertion clears the register without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/loopback_err_counter.sv
// Checks the loopback receive stream against a regenerated incrementing pattern and
// accumulates mismatches into a saturating count; LOOPBACK_ERR_CNT_BITERR_EN counts bits instead of words.
module loopback_err_counter
  import loopback_err_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int INCR        = 1,
  parameter int LOST_THRESH = 4
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_sync,
  input  logic              cnt_rst,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_pulse,
  output logic              locked
);

  localparam logic [DATA_W-1:0] INCR_V   = DATA_W'(INCR);
  localparam logic [MISS_W-1:0] MISS_END = MISS_W'(LOST_THRESH - 1);

  lb_state_e         state_q;
  logic [DATA_W-1:0] expected_q;
  logic [MISS_W-1:0] miss_run_q;
  logic              err_pulse_q;
  logic              locked_q;
  logic              cnt_rst_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  err_cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W:0]    cnt_sum;
  logic              cnt_clr;

  // A sync request or the first valid word while unlocked reseeds the pattern and is never an error.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= UNLOCKED;
      expected_q  <= '0;
      miss_run_q  <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      locked_q    <= (state_q == LOCKED);
      if (rx_valid && (rx_sync || state_q == UNLOCKED)) begin
        expected_q <= rx_data + INCR_V;
        miss_run_q <= '0;
        state_q    <= LOCKED;
      end else if (rx_sync) begin
        miss_run_q <= '0;
        state_q    <= UNLOCKED;
      end else if (rx_valid) begin
        expected_q <= expected_q + INCR_V;
        if (rx_data != expected_q) begin
          err_pulse_q <= 1'b1;
          if (miss_run_q == MISS_END) begin
            miss_run_q <= '0;
            state_q    <= UNLOCKED;
          end else begin
            miss_run_q <= miss_run_q + 1'b1;
          end
        end else begin
          miss_run_q <= '0;
        end
      end
    end
  end

`ifdef LOOPBACK_ERR_CNT_BITERR_EN
  localparam int POP_W = pop_w(DATA_W);
  logic [POP_W-1:0] pop_q;

  loopback_popcount #(
    .DATA_W (DATA_W)
  ) u_popcount (
    .clk     (user_clk),
    .rst     (user_rst),
    .data_i  (rx_data ^ expected_q),
    .count_o (pop_q)
  );

  assign cnt_inc = err_pulse_q ? CNT_W'(pop_q) : '0;
`else
  assign cnt_inc = CNT_W'(err_pulse_q);
`endif

  // A rising edge of the software clear beats an increment landing in the same cycle.
  always_comb begin
    cnt_clr = cnt_rst & ~cnt_rst_q;
    cnt_sum = {1'b0, err_cnt_q} + {1'b0, cnt_inc};
    if (cnt_clr)             err_cnt_d = '0;
    else if (cnt_sum[CNT_W]) err_cnt_d = CNT_MAX;
    else                     err_cnt_d = cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      cnt_rst_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cnt_rst_q <= cnt_rst;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt   = err_cnt_q;
  assign err_pulse = err_pulse_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_loopback_err_counter.sv
// Directed self-checking bench for loopback_err_counter; expectations follow the
// LOOPBACK_ERR_CNT_BITERR_EN macro when the bench is built with it.
module tb_loopback_err_counter;

`ifdef LOOPBACK_ERR_CNT_BITERR_EN
  localparam bit BITERR = 1'b1;
`else
  localparam bit BITERR = 1'b0;
`endif

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_sync;
  logic        cnt_rst;
  logic [31:0] err_cnt;
  logic        err_pulse;
  logic        locked;

  int n_pass  = 0;
  int n_total = 0;

  loopback_err_counter #(
    .DATA_W      (32),
    .INCR        (1),
    .LOST_THRESH (4)
  ) dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sync   (rx_sync),
    .cnt_rst   (cnt_rst),
    .err_cnt   (err_cnt),
    .err_pulse (err_pulse),
    .locked    (locked)
  );

  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one word at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic [31:0] d, input logic v, input logic s);
    rx_data  = d;
    rx_valid = v;
    rx_sync  = s;
    @(negedge user_clk);
  endtask

  function automatic logic [31:0] w(input logic [31:0] words, input logic [31:0] bits);
    return BITERR ? bits : words;
  endfunction

  task automatic pulse_reset();
    user_rst = 1'b1;
    @(negedge user_clk);
    user_rst = 1'b0;
  endtask

  initial begin
    user_rst = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    rx_sync  = 1'b0;
    cnt_rst  = 1'b0;
    @(negedge user_clk);
    @(negedge user_clk);
    check("rst_cnt",    err_cnt,          32'd0);
    check("rst_pulse",  {31'd0, err_pulse}, 32'd0);
    check("rst_locked", {31'd0, locked},    32'd0);
    user_rst = 1'b0;

    // 1: contiguous pattern 0..99
    for (int i = 0; i < 100; i++) begin
      cyc(32'(i), 1'b1, 1'b0);
      check("t1_pulse", {31'd0, err_pulse}, 32'd0);
      check("t1_locked", {31'd0, locked}, (i == 0) ? 32'd0 : 32'd1);
    end
    cyc(32'd0, 1'b0, 1'b0);
    check("t1_cnt", err_cnt, 32'd0);

    // 2: single corrupted word after sync seed on 10
    cyc(32'd10, 1'b1, 1'b1);
    cyc(32'd11, 1'b1, 1'b0);
    cyc(32'd12, 1'b1, 1'b0);
    check("t2_pulse12", {31'd0, err_pulse}, 32'd0);
    cyc(32'hDEAD, 1'b1, 1'b0);
    check("t2_pulse_bad", {31'd0, err_pulse}, 32'd1);
    check("t2_cnt_early", err_cnt, 32'd0);
    cyc(32'd14, 1'b1, 1'b0);
    check("t2_pulse14", {31'd0, err_pulse}, 32'd0);
    check("t2_cnt", err_cnt, w(32'd1, 32'd8));
    cyc(32'd15, 1'b1, 1'b0);
    check("t2_cnt_hold", err_cnt, w(32'd1, 32'd8));
    check("t2_locked", {31'd0, locked}, 32'd1);

    // mid-stream asynchronous reset
    user_rst = 1'b1;
    #1;
    check("arst_cnt",    err_cnt,          32'd0);
    check("arst_locked", {31'd0, locked},    32'd0);
    @(negedge user_clk);
    user_rst = 1'b0;

    // 3: dropped word -> four misses -> unlock, then re-lock
    cyc(32'd5, 1'b1, 1'b0);
    cyc(32'd6, 1'b1, 1'b0);
    cyc(32'h7777, 1'b0, 1'b0);
    check("t3_idle_pulse", {31'd0, err_pulse}, 32'd0);
    cyc(32'd8, 1'b1, 1'b0);
    check("t3_pulse8", {31'd0, err_pulse}, 32'd1);
    cyc(32'd9, 1'b1, 1'b0);
    check("t3_cnt9", err_cnt, w(32'd1, 32'd4));
    cyc(32'd10, 1'b1, 1'b0);
    check("t3_cnt10", err_cnt, w(32'd2, 32'd5));
    cyc(32'd11, 1'b1, 1'b0);
    check("t3_pulse11", {31'd0, err_pulse}, 32'd1);
    check("t3_cnt11", err_cnt, w(32'd3, 32'd7));
    check("t3_locked11", {31'd0, locked}, 32'd1);
    cyc(32'd12, 1'b1, 1'b0);
    check("t3_pulse12", {31'd0, err_pulse}, 32'd0);
    check("t3_cnt12", err_cnt, w(32'd4, 32'd8));
    check("t3_unlocked", {31'd0, locked}, 32'd0);
    cyc(32'd13, 1'b1, 1'b0);
    check("t3_relocked", {31'd0, locked}, 32'd1);
    check("t3_pulse13", {31'd0, err_pulse}, 32'd0);
    cyc(32'd0, 1'b0, 1'b0);
    check("t3_cnt_hold", err_cnt, w(32'd4, 32'd8));

    // 4: pattern wrap, then saturation
    pulse_reset();
    cyc(32'hFFFF_FFFE, 1'b1, 1'b0);
    cyc(32'hFFFF_FFFF, 1'b1, 1'b0);
    check("t4_pulse_ff", {31'd0, err_pulse}, 32'd0);
    cyc(32'h0000_0000, 1'b1, 1'b0);
    check("t4_pulse_0", {31'd0, err_pulse}, 32'd0);
    cyc(32'h0000_0001, 1'b1, 1'b0);
    check("t4_pulse_1", {31'd0, err_pulse}, 32'd0);
    cyc(32'd0, 1'b0, 1'b0);
    check("t4_cnt_wrap", err_cnt, 32'd0);
    check("t4_locked", {31'd0, locked}, 32'd1);
    force dut.err_cnt_q = 32'hFFFF_FFFE;
    cyc(32'd0, 1'b0, 1'b0);
    release dut.err_cnt_q;
    check("t4_preload", err_cnt, 32'hFFFF_FFFE);
    cyc(32'h100, 1'b1, 1'b0);
    check("t4_pulse_e1", {31'd0, err_pulse}, 32'd1);
    cyc(32'h100, 1'b1, 1'b0);
    check("t4_cnt_e1", err_cnt, 32'hFFFF_FFFF);
    cyc(32'h100, 1'b1, 1'b0);
    check("t4_cnt_e2", err_cnt, 32'hFFFF_FFFF);
    cyc(32'd0, 1'b0, 1'b0);
    check("t4_cnt_e3", err_cnt, 32'hFFFF_FFFF);
    cyc(32'd0, 1'b0, 1'b0);
    check("t4_cnt_sat", err_cnt, 32'hFFFF_FFFF);
    check("t4_locked_sat", {31'd0, locked}, 32'd1);

    // 5: software clear racing an increment, then held level
    cyc(32'd5, 1'b1, 1'b0);
    check("t5_pulse5", {31'd0, err_pulse}, 32'd0);
    cyc(32'h100, 1'b1, 1'b0);
    check("t5_pulse_bad", {31'd0, err_pulse}, 32'd1);
    cnt_rst = 1'b1;
    cyc(32'd7, 1'b1, 1'b0);
    check("t5_clear_wins", err_cnt, 32'd0);
    cyc(32'h100, 1'b1, 1'b0);
    check("t5_cnt_after_clr", err_cnt, 32'd0);
    cyc(32'd9, 1'b1, 1'b0);
    check("t5_grow1", err_cnt, w(32'd1, 32'd2));
    cyc(32'h100, 1'b1, 1'b0);
    cyc(32'd11, 1'b1, 1'b0);
    check("t5_grow2", err_cnt, w(32'd2, 32'd5));
    check("t5_locked", {31'd0, locked}, 32'd1);
    cnt_rst = 1'b0;
    cyc(32'd0, 1'b0, 1'b0);
    check("t5_hold", err_cnt, w(32'd2, 32'd5));

    // 6: bit-error weight and mid-stream resync
    pulse_reset();
    cyc(32'h0F, 1'b1, 1'b0);
    cyc(32'h1F, 1'b1, 1'b0);
    check("t6_pulse", {31'd0, err_pulse}, 32'd1);
    cyc(32'h11, 1'b1, 1'b0);
    check("t6_cnt", err_cnt, w(32'd1, 32'd4));
    cyc(32'h500, 1'b1, 1'b1);
    check("t6_sync_pulse", {31'd0, err_pulse}, 32'd0);
    cyc(32'h501, 1'b1, 1'b0);
    check("t6_501_pulse", {31'd0, err_pulse}, 32'd0);
    cyc(32'h502, 1'b1, 1'b0);
    check("t6_502_pulse", {31'd0, err_pulse}, 32'd0);
    check("t6_cnt_sync", err_cnt, w(32'd1, 32'd4));
    check("t6_locked", {31'd0, locked}, 32'd1);
    cyc(32'd0, 1'b0, 1'b1);
    check("t6_sync_nv_prev", {31'd0, locked}, 32'd1);
    cyc(32'd0, 1'b0, 1'b0);
    check("t6_sync_nv_unlock", {31'd0, locked}, 32'd0);
    cyc(32'h77, 1'b1, 1'b0);
    check("t6_seed_pulse", {31'd0, err_pulse}, 32'd0);
    cyc(32'h78, 1'b1, 1'b0);
    check("t6_78_pulse", {31'd0, err_pulse}, 32'd0);
    cyc(32'd0, 1'b0, 1'b0);
    check("t6_relock", {31'd0, locked}, 32'd1);
    check("t6_cnt_final", err_cnt, w(32'd1, 32'd4));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
